// File: rtl/code_conv_pkg.sv
// Shared mode encoding and digit limits for the pipelined code converter.
package code_conv_pkg;

  typedef enum logic [1:0] {
    CM_BIN2GRAY = 2'd0,
    CM_BCD2XS3  = 2'd1,
    CM_GRAY2BIN = 2'd2,
    CM_XS32BCD  = 2'd3
  } conv_mode_e;

  localparam logic [3:0] XS3_OFFSET = 4'd3;
  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam logic [3:0] XS3_MIN    = 4'd3;
  localparam logic [3:0] XS3_MAX    = 4'd12;

endpackage

// File: rtl/code_conv_digit.sv
// Combinational single-nibble BCD <-> excess-3 converter with digit-validity flag.
module code_conv_digit
  import code_conv_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       to_xs3_i,
  output logic [3:0] digit_o,
  output logic       invalid_o
);

  // Invalid digits are still converted mod 16 so the output is deterministic.
  always_comb begin
    digit_o   = digit_i;
    invalid_o = 1'b0;
    if (to_xs3_i) begin
      digit_o   = digit_i + XS3_OFFSET;
      invalid_o = (digit_i > BCD_MAX);
    end else begin
      digit_o   = digit_i - XS3_OFFSET;
      invalid_o = (digit_i < XS3_MIN) || (digit_i > XS3_MAX);
    end
  end

endmodule

// File: rtl/code_converter_pipe.sv
// Two-stage valid/ready code converter: bin<->gray and BCD<->excess-3 per transfer.
// Optional saturating error counter enabled by defining CODE_CONV_ERRCNT_EN.
module code_converter_pipe
  import code_conv_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_mode,
  output logic             out_err,
  output logic [15:0]      err_count
);

  localparam int unsigned NumDigits = WIDTH / 4;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q, s1_data_d;
  conv_mode_e       s1_mode_q, s1_mode_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  conv_mode_e       out_mode_q, out_mode_d;
  logic             out_err_q, out_err_d;

  logic             s1_ready, s2_ready;
  logic             to_xs3;
  logic [WIDTH-1:0] xs3_data, gray2bin, conv_data;
  logic [NumDigits-1:0] dig_inv;
  logic             conv_err;

  assign s2_ready = !out_valid_q || out_ready;
  assign s1_ready = !s1_valid_q || s2_ready;
  assign in_ready = s1_ready;
  assign to_xs3   = (s1_mode_q == CM_BCD2XS3);

  for (genvar g = 0; g < NumDigits; g++) begin : g_digit
    code_conv_digit u_digit (
      .digit_i   (s1_data_q[4*g +: 4]),
      .to_xs3_i  (to_xs3),
      .digit_o   (xs3_data[4*g +: 4]),
      .invalid_o (dig_inv[g])
    );
  end

  always_comb begin
    // Each binary bit is the XOR of all gray bits from its position up to the MSB.
    gray2bin = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      gray2bin[i] = ^(s1_data_q >> i);
    end
    conv_data = s1_data_q ^ (s1_data_q >> 1);
    conv_err  = 1'b0;
    unique case (s1_mode_q)
      CM_BIN2GRAY: conv_data = s1_data_q ^ (s1_data_q >> 1);
      CM_GRAY2BIN: conv_data = gray2bin;
      CM_BCD2XS3, CM_XS32BCD: begin
        conv_data = xs3_data;
        conv_err  = |dig_inv;
      end
      default: ;
    endcase
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_mode_d   = s1_mode_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_mode_d  = out_mode_q;
    out_err_d   = out_err_q;
    if (s1_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = in_data;
        s1_mode_d = conv_mode_e'(in_mode);
      end
    end
    if (s2_ready) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = conv_data;
        out_mode_d = s1_mode_q;
        out_err_d  = conv_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_mode_q   <= CM_BIN2GRAY;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_mode_q  <= CM_BIN2GRAY;
      out_err_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_mode_q   <= s1_mode_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_mode_q  <= out_mode_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_mode  = out_mode_q;
  assign out_err   = out_err_q;

`ifdef CODE_CONV_ERRCNT_EN
  logic [15:0] err_count_q, err_count_d;

  // Counted on the handshake only, so a stalled error word is counted once.
  always_comb begin
    err_count_d = err_count_q;
    if (out_valid_q && out_ready && out_err_q && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_q <= 16'h0000;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`else
  assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_code_converter_pipe.sv
// Scoreboard bench for code_converter_pipe (WIDTH=8); driver queues expectations, monitor checks.
module tb_code_converter_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic [1:0] in_mode = 2'b00;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic [1:0] out_mode;
  logic       out_err;
  logic [15:0] err_count;

  code_converter_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode),
    .out_err   (out_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] mode;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   deliv_cycle[$];
  int   exp_errcnt = 0;
  int   last_waits = 0;

  logic       stall_prev = 1'b0;
  logic [7:0] hold_data;
  logic [1:0] hold_mode;
  logic       hold_err;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: values are stable at negedge, the handshake completes at the following posedge.
  always @(negedge clk) begin
    if (!rst && stall_prev) begin
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_data", {24'd0, out_data}, {24'd0, hold_data});
      check("hold_mode", {30'd0, out_mode}, {30'd0, hold_mode});
      check("hold_err", {31'd0, out_err}, {31'd0, hold_err});
    end
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got data %0h mode %0d with empty scoreboard",
                 out_data, out_mode);
      end else begin
        mon_e = sb_q.pop_front();
        check("out_data", {24'd0, out_data}, {24'd0, mon_e.data});
        check("out_mode", {30'd0, out_mode}, {30'd0, mon_e.mode});
        check("out_err", {31'd0, out_err}, {31'd0, mon_e.err});
        deliv_cycle.push_back(cycle);
        if (mon_e.err) exp_errcnt++;
      end
    end
    stall_prev = !rst && out_valid && !out_ready;
    hold_data  = out_data;
    hold_mode  = out_mode;
    hold_err   = out_err;
  end

  // Call just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [7:0] d, input logic [1:0] m, input logic [7:0] ed,
                      input logic ee);
    in_data  = d;
    in_mode  = m;
    in_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back({ed, m, ee});
        last_waits = t;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: in_ready never 1 for data %0h, required acceptance", d);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (sb_q.size() == 0) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout: %0d words still pending, required 0", sb_q.size());
    sb_q.delete();
  endtask

  function automatic logic [15:0] errcnt_exp(input int n);
`ifdef CODE_CONV_ERRCNT_EN
    return 16'(n);
`else
    return 16'h0000 + 16'(n & 0);
`endif
  endfunction

  logic [7:0] t3_d[8]  = '{8'h47, 8'h4C, 8'h7A, 8'h2A, 8'h3C, 8'hD3, 8'h99, 8'h9A};
  logic [1:0] t3_m[8]  = '{2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3, 2'd1, 2'd1};
  logic [7:0] t3_e[8]  = '{8'h7A, 8'h7F, 8'h47, 8'hF7, 8'h09, 8'hA0, 8'hCC, 8'hCD};
  logic       t3_r[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    logic [7:0] b;
    int base;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_out_mode", {30'd0, out_mode}, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_err_count", {16'd0, err_count}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Latency: accepted at edge k, output visible after edge k+1.
    send(8'hB5, 2'd0, 8'hEF, 1'b0);
    @(negedge clk);
    check("latency_early", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("latency_2cyc", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    drain();

    send(8'hEF, 2'd2, 8'hB5, 1'b0);
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      send(b, 2'd0, b ^ (b >> 1), 1'b0);
    end
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      send(b ^ (b >> 1), 2'd2, b, 1'b0);
    end
    drain();

    for (int i = 0; i < 8; i++) send(t3_d[i], t3_m[i], t3_e[i], t3_r[i]);
    drain();

    // Back-to-back burst.
    base = deliv_cycle.size();
    send(8'h12, 2'd0, 8'h1B, 1'b0);
    check("burst_ready0", last_waits, 0);
    send(8'h25, 2'd1, 8'h58, 1'b0);
    check("burst_ready1", last_waits, 0);
    send(8'h1B, 2'd2, 8'h12, 1'b0);
    check("burst_ready2", last_waits, 0);
    send(8'h58, 2'd3, 8'h25, 1'b0);
    check("burst_ready3", last_waits, 0);
    drain();
    for (int k = 1; k < 4; k++) begin
      check("burst_consecutive", deliv_cycle[base + k] - deliv_cycle[base], k);
    end

    // Backpressure: two words fill the pipe, third waits.
    out_ready = 1'b0;
    send(8'h4C, 2'd1, 8'h7F, 1'b1);
    send(8'h7A, 2'd3, 8'h47, 1'b0);
    in_data  = 8'hB5;
    in_mode  = 2'd0;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(8'hB5, 2'd0, 8'hEF, 1'b0);
    drain();
    check("err_count_run", {16'd0, err_count}, {16'd0, errcnt_exp(exp_errcnt)});

    // Reset with both stages full drops both words.
    out_ready = 1'b0;
    send(8'h01, 2'd0, 8'h01, 1'b0);
    send(8'h02, 2'd0, 8'h03, 1'b0);
    rst = 1'b1;
    sb_q.delete();
    exp_errcnt = 0;
    @(posedge clk);
    @(negedge clk);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    check("flush_err_count", {16'd0, err_count}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("no_stale", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;

    send(8'h4C, 2'd1, 8'h7F, 1'b1);
    send(8'h2A, 2'd3, 8'hF7, 1'b1);
    send(8'hD3, 2'd3, 8'hA0, 1'b1);
    drain();
    check("err_count_three", {16'd0, err_count}, {16'd0, errcnt_exp(3)});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
